// File: rtl/ng_alu_seq.sv
// ---------------------------------------------------------------------------
// ng_alu_seq -- micro-sequencer for the ALU datapath (B, X, Y, C registers plus
// adder/function unit). Accepts one operation at a time, steps through the
// T-states of that operation emitting active-low ALU control pulses and the
// operand on WRITE_BUS, captures ALU_OUT, and returns it over a valid/ready
// response handshake.
//
// Ports
//   CLK2                 clock, all state changes on posedge
//   RESET_N              synchronous reset, active-low
//   REQ_VALID/REQ_READY  request handshake (READY only while idle)
//   REQ_OP               0 ADD, 1 SUB, 2 INC, 3 COM, 4 PASS, 5 CLR, 6-7 illegal
//   REQ_A, REQ_B         operands, latched on accept
//   ALU_OUT              combinational ALU function output
//   WRITE_BUS            operand to the ALU, 0 when no write pulse is active
//   WB_N..RU_N           ALU control pulses, active-low, one T-step per clock
//   RESP_VALID/READY     response handshake, response held until accepted
//   RESULT, RESP_ERR     captured ALU_OUT / illegal-opcode flag
// ---------------------------------------------------------------------------
module ng_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK2,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [2:0]       REQ_OP,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] WRITE_BUS,
  output logic             WB_N,
  output logic             WX_N,
  output logic             WY_N,
  output logic             WYX_N,
  output logic             CI_N,
  output logic             RB_N,
  output logic             RC_N,
  output logic             RU_N,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESP_ERR
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;
  localparam logic [2:0] S_T5   = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_COM  = 3'd3;
  localparam logic [2:0] OP_PASS = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;

  // Bit positions inside the active-low pulse vector.
  localparam int P_WB = 7, P_WX = 6, P_WY = 5, P_WYX = 4;
  localparam int P_CI = 3, P_RB = 2, P_RC = 1, P_RU = 0;

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             resp_valid_q, resp_valid_d;
  logic             ready_q, ready_d;
  logic [7:0]       pulses_q, pulses_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [2:0]       last_step;

  // Final T-step of the latched operation; its closing edge captures RESULT.
  always_comb begin
    case (op_q)
      OP_ADD:                   last_step = S_T3;
      OP_SUB:                   last_step = S_T5;
      OP_INC, OP_COM, OP_PASS:  last_step = S_T2;
      default:                  last_step = S_T1;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tmp_d        = tmp_q;
    result_d     = result_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          op_d = REQ_OP;
          a_d  = REQ_A;
          b_d  = REQ_B;
          if (REQ_OP > OP_CLR) begin
            // Illegal opcode: no T-steps, answer immediately with an error.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            result_d     = '0;
          end else begin
            state_d = S_T1;
            err_d   = 1'b0;
          end
        end
      end
      S_T1, S_T2, S_T3, S_T4, S_T5: begin
        // SUB parks ~B in TMP at the end of T2 to feed it back in T4.
        if (op_q == OP_SUB && state_q == S_T2) tmp_d = ALU_OUT;
        if (state_q == last_step) begin
          result_d     = ALU_OUT;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          state_d = state_q + 3'd1;
        end
      end
      S_RESP: begin
        if (RESP_READY) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pulses line
    // up exactly with the T-step they belong to.
    ready_d  = (state_d == S_IDLE);
    pulses_d = '1;
    bus_d    = '0;
    case (op_d)
      OP_ADD: begin
        case (state_d)
          S_T1:    begin pulses_d[P_WY] = 1'b0; bus_d = a_d; end
          S_T2:    begin pulses_d[P_WX] = 1'b0; bus_d = b_d; end
          S_T3:    pulses_d[P_RU] = 1'b0;
          default: ;
        endcase
      end
      OP_SUB: begin
        case (state_d)
          S_T1:    begin pulses_d[P_WB] = 1'b0; bus_d = b_d;   end
          S_T2:    pulses_d[P_RC] = 1'b0;
          S_T3:    begin pulses_d[P_WY] = 1'b0; bus_d = a_d;   end
          S_T4:    begin pulses_d[P_WX] = 1'b0; bus_d = tmp_d; end
          S_T5:    pulses_d[P_RU] = 1'b0;
          default: ;
        endcase
      end
      OP_INC: begin
        case (state_d)
          S_T1: begin
            pulses_d[P_WY] = 1'b0;
            pulses_d[P_CI] = 1'b0;
            bus_d          = a_d;
          end
          S_T2:    pulses_d[P_RU] = 1'b0;
          default: ;
        endcase
      end
      OP_COM, OP_PASS: begin
        case (state_d)
          S_T1:    begin pulses_d[P_WB] = 1'b0; bus_d = a_d; end
          S_T2:    pulses_d[(op_d == OP_COM) ? P_RC : P_RB] = 1'b0;
          default: ;
        endcase
      end
      // CLR: ALU defaults to zero with no pulses; illegal ops have no steps.
      default: ;
    endcase
    // WYX is not used by any current operation.
    pulses_d[P_WYX] = 1'b1;
  end

  always_ff @(posedge CLK2) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      tmp_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      pulses_q     <= '1;
      bus_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed in the combinational block.
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tmp_q        <= tmp_d;
      result_q     <= result_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      ready_q      <= ready_d;
      pulses_q     <= pulses_d;
      bus_q        <= bus_d;
    end
  end

  assign REQ_READY  = ready_q;
  assign WRITE_BUS  = bus_q;
  assign WB_N       = pulses_q[P_WB];
  assign WX_N       = pulses_q[P_WX];
  assign WY_N       = pulses_q[P_WY];
  assign WYX_N      = pulses_q[P_WYX];
  assign CI_N       = pulses_q[P_CI];
  assign RB_N       = pulses_q[P_RB];
  assign RC_N       = pulses_q[P_RC];
  assign RU_N       = pulses_q[P_RU];
  assign RESP_VALID = resp_valid_q;
  assign RESULT     = result_q;
  assign RESP_ERR   = err_q;

endmodule

// File: tb/tb_ng_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_ng_alu_seq -- self-checking bench for ng_alu_seq. Contains a small ALU
// (B, X, Y, C registers) reacting to the control pulses, a table-driven
// reference model of the expected per-cycle outputs, a compare process that
// checks every cycle, and directed operations with hand-computed results.
// ---------------------------------------------------------------------------
module tb_ng_alu_seq;

  logic        CLK2 = 1'b0;
  logic        RESET_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_OP;
  logic [15:0] REQ_A, REQ_B;
  logic [15:0] ALU_OUT;
  logic [15:0] WRITE_BUS;
  logic        WB_N, WX_N, WY_N, WYX_N, CI_N, RB_N, RC_N, RU_N;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [15:0] RESULT;
  logic        RESP_ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK2 = ~CLK2;

  ng_alu_seq #(.WIDTH(16)) dut (
    .CLK2(CLK2), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .ALU_OUT(ALU_OUT), .WRITE_BUS(WRITE_BUS),
    .WB_N(WB_N), .WX_N(WX_N), .WY_N(WY_N), .WYX_N(WYX_N), .CI_N(CI_N),
    .RB_N(RB_N), .RC_N(RC_N), .RU_N(RU_N),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESULT(RESULT), .RESP_ERR(RESP_ERR)
  );

  logic [7:0] dut_pulses;
  assign dut_pulses = {WB_N, WX_N, WY_N, WYX_N, CI_N, RB_N, RC_N, RU_N};

  // ---------------- ALU: writes at posedge, function output combinational
  logic [15:0] alu_b = '0, alu_x = '0, alu_y = '0;
  logic        alu_c = 1'b0;
  always @(posedge CLK2) begin
    if (!WB_N) alu_b <= WRITE_BUS;
    if (!WY_N) begin
      alu_y <= WRITE_BUS;
      alu_x <= '0;
      alu_c <= !CI_N;
    end
    if (!WX_N) alu_x <= WRITE_BUS;
  end
  assign ALU_OUT = !RU_N ? alu_x + alu_y + 16'(alu_c) :
                   !RC_N ? ~alu_b :
                   !RB_N ? alu_b : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-op step tables from the op semantics
  localparam logic [7:0] M_WB = 8'h80, M_WX = 8'h40, M_WY = 8'h20, M_CI = 8'h08;
  localparam logic [7:0] M_RB = 8'h04, M_RC = 8'h02, M_RU = 8'h01;

  typedef struct packed {
    logic [7:0]  pulses;
    logic [15:0] bus;
  } step_t;

  typedef enum {M_IDLE, M_STEPS, M_RESP} mstate_t;

  step_t       m_q[$];
  mstate_t     m_state = M_IDLE;
  bit          m_valid = 1'b0;
  logic [7:0]  exp_pulses;
  logic [15:0] exp_bus;
  logic [15:0] exp_result;
  logic        exp_err;

  task automatic build_steps(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    m_q.delete();
    case (op)
      3'd0: begin
        m_q.push_back(step_t'({~M_WY, a}));
        m_q.push_back(step_t'({~M_WX, b}));
        m_q.push_back(step_t'({~M_RU, 16'h0}));
      end
      3'd1: begin
        m_q.push_back(step_t'({~M_WB, b}));
        m_q.push_back(step_t'({~M_RC, 16'h0}));
        m_q.push_back(step_t'({~M_WY, a}));
        m_q.push_back(step_t'({~M_WX, ~b}));
        m_q.push_back(step_t'({~M_RU, 16'h0}));
      end
      3'd2: begin
        m_q.push_back(step_t'({~(M_WY | M_CI), a}));
        m_q.push_back(step_t'({~M_RU, 16'h0}));
      end
      3'd3: begin
        m_q.push_back(step_t'({~M_WB, a}));
        m_q.push_back(step_t'({~M_RC, 16'h0}));
      end
      3'd4: begin
        m_q.push_back(step_t'({~M_WB, a}));
        m_q.push_back(step_t'({~M_RB, 16'h0}));
      end
      3'd5: m_q.push_back(step_t'({8'hFF, 16'h0}));
      default: ;
    endcase
  endtask

  function automatic logic [16:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    // {err, result}
    case (op)
      3'd0:    return {1'b0, 16'(a + b)};
      3'd1:    return {1'b0, 16'(a + ~b)};
      3'd2:    return {1'b0, 16'(a + 16'd1)};
      3'd3:    return {1'b0, ~a};
      3'd4:    return {1'b0, a};
      3'd5:    return {1'b0, 16'h0};
      default: return {1'b1, 16'h0};
    endcase
  endfunction

  initial forever begin
    step_t s;
    @(posedge CLK2);
    if (!RESET_N) begin
      m_state = M_IDLE;
      m_q.delete();
      m_valid = 1'b1;
    end else begin
      case (m_state)
        M_IDLE: if (REQ_VALID) begin
          build_steps(REQ_OP, REQ_A, REQ_B);
          {exp_err, exp_result} = ref_result(REQ_OP, REQ_A, REQ_B);
          m_state = M_STEPS;
        end
        M_RESP: if (RESP_READY) m_state = M_IDLE;
        default: ;
      endcase
      if (m_state == M_STEPS) begin
        if (m_q.size() > 0) begin
          s          = m_q.pop_front();
          exp_pulses = s.pulses;
          exp_bus    = s.bus;
        end else begin
          m_state = M_RESP;
        end
      end
    end
    if (m_state != M_STEPS) begin
      exp_pulses = 8'hFF;
      exp_bus    = 16'h0;
    end
  end

  // ---------------- compare process, one sample per cycle on the falling edge
  initial forever begin
    @(negedge CLK2);
    if (m_valid) begin
      check("cmp_pulses", 32'(dut_pulses), 32'(exp_pulses));
      check("cmp_bus", 32'(WRITE_BUS), 32'(exp_bus));
      check("cmp_req_ready", 32'(REQ_READY), 32'(m_state == M_IDLE));
      check("cmp_resp_valid", 32'(RESP_VALID), 32'(m_state == M_RESP));
      if (m_state == M_RESP) begin
        check("cmp_result", 32'(RESULT), 32'(exp_result));
        check("cmp_resp_err", 32'(RESP_ERR), 32'(exp_err));
      end
    end
  end

  // ---------------- directed operations with literal expectations
  task automatic do_op(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int exp_lat, input logic [15:0] exp_res,
                       input logic exp_e, input logic [7:0] exp_t1, input int hold);
    int wait_cnt = 0;
    int lat;
    logic [15:0] held;
    while (!REQ_READY && wait_cnt < 20) begin
      @(negedge CLK2);
      wait_cnt++;
    end
    check({name, "_ready_wait"}, 32'(REQ_READY), 32'd1);
    RESP_READY = (hold == 0);
    REQ_VALID  = 1'b1;
    REQ_OP     = op;
    REQ_A      = a;
    REQ_B      = b;
    @(negedge CLK2);
    REQ_VALID = 1'b0;
    check({name, "_t1_pulses"}, 32'(dut_pulses), 32'(exp_t1));
    lat = 1;
    while (!RESP_VALID && lat < 20) begin
      @(negedge CLK2);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, 32'(RESULT), 32'(exp_res));
    check({name, "_err"}, 32'(RESP_ERR), 32'(exp_e));
    held = RESULT;
    for (int i = 0; i < hold; i++) begin
      // A request offered while busy must be dropped, not queued.
      REQ_VALID = 1'b1;
      REQ_OP    = 3'd0;
      check({name, "_hold_result"}, 32'(RESULT), 32'(held));
      check({name, "_hold_ready"}, 32'(REQ_READY), 32'd0);
      @(negedge CLK2);
    end
    REQ_VALID  = 1'b0;
    RESP_READY = 1'b1;
    @(negedge CLK2);
    check({name, "_resp_drop"}, 32'(RESP_VALID), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N    = 1'b0;
    REQ_VALID  = 1'b0;
    REQ_OP     = 3'd0;
    REQ_A      = 16'h0;
    REQ_B      = 16'h0;
    RESP_READY = 1'b1;
    repeat (2) @(negedge CLK2);
    check("rst_ready", 32'(REQ_READY), 32'd1);
    check("rst_valid", 32'(RESP_VALID), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    check("rst_pulses", 32'(dut_pulses), 32'hFF);
    RESET_N = 1'b1;
    @(negedge CLK2);

    do_op("add",      3'd0, 16'h0003, 16'h0004, 4, 16'h0007, 1'b0, 8'hDF, 0);
    do_op("sub",      3'd1, 16'h0002, 16'h0005, 6, 16'hFFFC, 1'b0, 8'h7F, 0);
    do_op("inc",      3'd2, 16'h0007, 16'h0000, 3, 16'h0008, 1'b0, 8'hD7, 0);
    do_op("com",      3'd3, 16'h00F0, 16'h0000, 3, 16'hFF0F, 1'b0, 8'h7F, 0);
    do_op("pass",     3'd4, 16'h1234, 16'h0000, 3, 16'h1234, 1'b0, 8'h7F, 5);
    do_op("ill6",     3'd6, 16'hAAAA, 16'h5555, 1, 16'h0000, 1'b1, 8'hFF, 0);
    do_op("ill7",     3'd7, 16'h1111, 16'h2222, 1, 16'h0000, 1'b1, 8'hFF, 0);
    do_op("clr",      3'd5, 16'hBEEF, 16'h0000, 2, 16'h0000, 1'b0, 8'hFF, 0);
    do_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 4, 16'h0000, 1'b0, 8'hDF, 0);
    do_op("sub_pos",  3'd1, 16'h0005, 16'h0002, 6, 16'h0002, 1'b0, 8'h7F, 0);

    // Reset in the middle of a SUB, during T3.
    REQ_VALID = 1'b1;
    REQ_OP    = 3'd1;
    REQ_A     = 16'h0002;
    REQ_B     = 16'h0005;
    @(negedge CLK2);
    REQ_VALID = 1'b0;
    repeat (2) @(negedge CLK2);
    check("midrst_t3_pulses", 32'(dut_pulses), 32'hDF);
    RESET_N = 1'b0;
    @(negedge CLK2);
    check("midrst_pulses", 32'(dut_pulses), 32'hFF);
    check("midrst_bus", 32'(WRITE_BUS), 32'd0);
    check("midrst_ready", 32'(REQ_READY), 32'd1);
    check("midrst_valid", 32'(RESP_VALID), 32'd0);
    check("midrst_result", 32'(RESULT), 32'd0);
    check("midrst_err", 32'(RESP_ERR), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK2);

    do_op("add_post", 3'd0, 16'h1000, 16'h0234, 4, 16'h1234, 1'b0, 8'hDF, 0);
    repeat (2) @(negedge CLK2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
